// File: rtl/bram_fifo_ctrl.sv
// FIFO controller for an external simple-dual-port BRAM (1-cycle read latency) with a
// 2-entry prefetch buffer giving first-word-fall-through output. Optional: BRAM_FIFO_ERR_EN.
module bram_fifo_ctrl #(
    parameter  int RAM_WIDTH = 64,
    parameter  int RAM_DEPTH = 512,
    localparam int AW = $clog2(RAM_DEPTH),
    localparam int CW = $clog2(RAM_DEPTH + 3)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [RAM_WIDTH-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 bram_wr_en,
    output logic [AW-1:0]        bram_addra,
    output logic [RAM_WIDTH-1:0] bram_dina,
    output logic                 bram_rd_en,
    output logic [AW-1:0]        bram_addrb,
    input  logic [RAM_WIDTH-1:0] bram_doutb,
    output logic [CW-1:0]        count,
    output logic                 empty,
    output logic                 full
`ifdef BRAM_FIFO_ERR_EN
    ,
    output logic                 overflow_err,
    output logic                 underflow_err,
    input  logic                 err_clr
`endif
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(RAM_DEPTH);

    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        ram_cnt;
    logic [CW-1:0]        ram_cnt_nxt;
    logic                 rd_inflight;
    logic [RAM_WIDTH-1:0] obuf [2];
    logic [1:0]           ob_cnt;
    logic [1:0]           ob_cnt_nxt;
    logic                 rst_done;
    logic                 accept;
    logic                 issue;
    logic                 pop;
    logic [2:0]           credit_used;
    logic [2:0]           credit_avail;

    // s_ready is held low until the first edge after reset release
    assign s_ready      = rst_done && (ram_cnt < DEPTH_CNT);
    assign accept       = s_valid && s_ready;
    assign pop          = m_valid && m_ready;
    assign m_valid      = (ob_cnt != 2'd0);
    assign m_data       = obuf[0];

    // Only issue a read if the output buffer will have room when the data lands
    assign credit_used  = {1'b0, ob_cnt} + {2'b00, rd_inflight};
    assign credit_avail = 3'd2 + {2'b00, pop};
    assign issue        = (ram_cnt != '0) && (credit_used < credit_avail);

    assign bram_wr_en   = accept;
    assign bram_addra   = wr_ptr;
    assign bram_dina    = s_data;
    assign bram_rd_en   = issue;
    assign bram_addrb   = rd_ptr;

    assign empty        = (count == '0);
    assign full         = (ram_cnt == DEPTH_CNT);

    always_comb begin
        ram_cnt_nxt = ram_cnt;
        ob_cnt_nxt  = ob_cnt;
        if (accept && !issue) begin
            ram_cnt_nxt = ram_cnt + CW'(1);
        end else if (!accept && issue) begin
            ram_cnt_nxt = ram_cnt - CW'(1);
        end
        if (rd_inflight && !pop) begin
            ob_cnt_nxt = ob_cnt + 2'd1;
        end else if (!rd_inflight && pop) begin
            ob_cnt_nxt = ob_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
            ob_cnt      <= 2'd0;
            count       <= '0;
        end else begin
            rst_done    <= 1'b1;
            if (accept) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + AW'(1);
            end
            ram_cnt     <= ram_cnt_nxt;
            rd_inflight <= issue;
            ob_cnt      <= ob_cnt_nxt;
            count       <= ram_cnt_nxt + CW'(issue) + CW'(ob_cnt_nxt);
        end
    end

    // obuf[0] is always the head; a simultaneous pop and capture shifts and refills
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obuf[0] <= '0;
            obuf[1] <= '0;
        end else begin
            case ({rd_inflight, pop})
                2'b10: begin
                    if (ob_cnt == 2'd0) begin
                        obuf[0] <= bram_doutb;
                    end else begin
                        obuf[1] <= bram_doutb;
                    end
                end
                2'b01: begin
                    obuf[0] <= obuf[1];
                end
                2'b11: begin
                    if (ob_cnt == 2'd2) begin
                        obuf[0] <= obuf[1];
                        obuf[1] <= bram_doutb;
                    end else begin
                        obuf[0] <= bram_doutb;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BRAM_FIFO_ERR_EN
    // Sticky flags; a new error event wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (s_valid && !s_ready) begin
                overflow_err <= 1'b1;
            end else if (err_clr) begin
                overflow_err <= 1'b0;
            end
            if (m_ready && !m_valid) begin
                underflow_err <= 1'b1;
            end else if (err_clr) begin
                underflow_err <= 1'b0;
            end
        end
    end
`endif

endmodule
